// File: rtl/cu_pkg.sv
// -----------------------------------------------------------------------------
// cu_pkg -- shared definitions for the basic-computer control unit.
//
// Holds the memory-reference opcodes, the register-reference bit masks
// (applied to the 12-bit address field of IR), the bus-select and
// accumulator-operation encodings driven on busSel/acOp, and the
// sequence-counter geometry used by seq_counter.
// -----------------------------------------------------------------------------
package cu_pkg;

  // Sequence counter: timing states T0..T6.
  localparam int SC_W      = 3;
  localparam int SC_STATES = 7;
  localparam logic [SC_W-1:0] SC_LAST = 3'd6;

  // Width of the register-reference field (low bits of IR).
  localparam int RR_W = 12;

  // Memory-reference opcodes (IR[14:12]); 7 selects register-reference / I/O.
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;

  // Register-reference bit masks.
  localparam logic [RR_W-1:0] RR_CLA = 12'h800;
  localparam logic [RR_W-1:0] RR_CLE = 12'h400;
  localparam logic [RR_W-1:0] RR_CMA = 12'h200;
  localparam logic [RR_W-1:0] RR_CME = 12'h100;
  localparam logic [RR_W-1:0] RR_CIR = 12'h080;
  localparam logic [RR_W-1:0] RR_CIL = 12'h040;
  localparam logic [RR_W-1:0] RR_INC = 12'h020;
  localparam logic [RR_W-1:0] RR_SPA = 12'h010;
  localparam logic [RR_W-1:0] RR_SNA = 12'h008;
  localparam logic [RR_W-1:0] RR_SZA = 12'h004;
  localparam logic [RR_W-1:0] RR_SZE = 12'h002;
  localparam logic [RR_W-1:0] RR_HLT = 12'h001;

  // Common-bus source select.
  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_AR   = 3'd1,
    BUS_PC   = 3'd2,
    BUS_DR   = 3'd3,
    BUS_AC   = 3'd4,
    BUS_IR   = 3'd5,
    BUS_MEM  = 3'd6
  } bus_sel_e;

  // Accumulator operation.
  typedef enum logic [3:0] {
    AC_NOP  = 4'd0,
    AC_AND  = 4'd1,
    AC_ADD  = 4'd2,
    AC_LOAD = 4'd3,
    AC_CLA  = 4'd4,
    AC_CLE  = 4'd5,
    AC_CMA  = 4'd6,
    AC_CME  = 4'd7,
    AC_CIR  = 4'd8,
    AC_CIL  = 4'd9,
    AC_INC  = 4'd10
  } ac_op_e;

  // Top-level sequencing phase of the control unit.
  typedef enum logic [1:0] {
    PH_RESET = 2'd0,  // in or just out of reset, waiting for the first edge
    PH_INIT  = 2'd1,  // one-cycle PC clear
    PH_RUN   = 2'd2,  // normal fetch/decode/execute
    PH_HALT  = 2'd3   // frozen until reset
  } phase_e;

  // acOp carries a single operation, so when several accumulator bits of a
  // register-reference instruction are set, the most significant one wins.
  function automatic ac_op_e rr_ac_op(input logic [RR_W-1:0] rr);
    if (|(rr & RR_CLA)) return AC_CLA;
    if (|(rr & RR_CLE)) return AC_CLE;
    if (|(rr & RR_CMA)) return AC_CMA;
    if (|(rr & RR_CME)) return AC_CME;
    if (|(rr & RR_CIR)) return AC_CIR;
    if (|(rr & RR_CIL)) return AC_CIL;
    if (|(rr & RR_INC)) return AC_INC;
    return AC_NOP;
  endfunction

endpackage

// File: rtl/seq_counter.sv
// -----------------------------------------------------------------------------
// seq_counter -- 3-bit timing-state counter with one-hot T decode.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (count -> 0)
//   clr    in   synchronous clear: next count is 0
//   inc    in   advance the count by one when not clearing
//   count  out  current sequence count (0..6)
//   t      out  one-hot timing states T0..T6
// The count wraps from 6 back to 0, so it never reaches 7.
// -----------------------------------------------------------------------------
module seq_counter
  import cu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 inc,
  output logic [SC_W-1:0]      count,
  output logic [SC_STATES-1:0] t
);

  // NOTE: state registers use non-blocking assignment so every flop samples
  // its inputs as they were before the clock edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || count == SC_LAST) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 3'd1;
    end
  end

  // NOTE: assigning a default at the top of every combinational block keeps
  // each output driven on every path, so no latch is inferred.
  always_comb begin
    t = '0;
    for (int i = 0; i < SC_STATES; i++) begin
      t[i] = (count == 3'(i));
    end
  end

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit -- hardwired control for a basic accumulator computer.
//
// Sequences fetch (T0..T2), indirect/decode (T3) and execute (T4..T6) and
// decodes the timing state, the latched opcode/indirect bit and the IR
// address field into datapath strobes.
//
// Parameters:
//   DATA_W  instruction/data word width (IR width)
//   ADDR_W  address/PC width; IR[ADDR_W+2:ADDR_W] is the opcode
// Ports:
//   CLK, RST_N              clock (rising edge), async active-low reset
//   IR                      current instruction register contents
//   irLD arLD arINR drLD drINR memRD memWR   datapath strobes
//   pcLD pcINR pcCLR ISZ SPA SNA SZA SZE     PC register controls
//   busSel / acOp           bus source and AC operation (cu_pkg encodings)
//   sc                      sequence count (timing state number)
//   halted                  set by the halt instruction
//
// Build option: define CU_HALT_EN to make register-reference bit 0x001 halt
// the machine until reset; otherwise that bit is a no-op and halted is 0.
//
// After reset is released the first clock edge enters a one-cycle INIT phase
// (pcCLR only, sc held at 0); the next edge starts T0. All strobes are gated
// by the run phase, which the async reset clears immediately, so an aborted
// instruction never completes a pending memory write.
// -----------------------------------------------------------------------------
module control_unit
  import cu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] IR,
  output logic              irLD,
  output logic              arLD,
  output logic              arINR,
  output logic              drLD,
  output logic              drINR,
  output logic              memRD,
  output logic              memWR,
  output logic              pcLD,
  output logic              pcINR,
  output logic              pcCLR,
  output logic              ISZ,
  output logic              SPA,
  output logic              SNA,
  output logic              SZA,
  output logic              SZE,
  output logic [2:0]        busSel,
  output logic [3:0]        acOp,
  output logic [2:0]        sc,
  output logic              halted
);

  phase_e                 phase;
  logic                   run;
  logic                   sc_clr;
  logic                   halt_req;
  logic [SC_STATES-1:0]   t;
  logic [2:0]             opcode;
  logic                   ind;
  logic [RR_W-1:0]        rr;

  assign rr  = IR[RR_W-1:0];
  assign run = (phase == PH_RUN);

  seq_counter u_seq (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (sc_clr),
    .inc   (run),
    .count (sc),
    .t     (t)
  );

  // Phase sequencing: reset -> INIT -> RUN, with an optional exit to HALT.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      phase <= PH_RESET;
    end else begin
      case (phase)
        PH_RESET: phase <= PH_INIT;
        PH_INIT:  phase <= PH_RUN;
        PH_RUN:   if (halt_req) phase <= PH_HALT;
        PH_HALT:  phase <= PH_HALT;
        default:  phase <= PH_RESET;
      endcase
    end
  end

  // Opcode and indirect bit are captured at the end of T2, once IR holds the
  // freshly fetched word; later states decode from these copies.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      opcode <= OP_AND;
      ind    <= 1'b0;
    end else if (run && t[2]) begin
      opcode <= IR[ADDR_W+2:ADDR_W];
      ind    <= IR[DATA_W-1];
    end
  end

`ifdef CU_HALT_EN
  assign halt_req = run && t[3] && (opcode == OP_REG) && !ind && |(rr & RR_HLT);
  assign halted   = (phase == PH_HALT);
`else
  logic unused_hlt_bit;
  assign unused_hlt_bit = |(rr & RR_HLT);
  assign halt_req       = 1'b0;
  assign halted         = 1'b0;
`endif

  // Sequence-counter clear: held outside the run phase, and at the last
  // timing state of each instruction class so the next cycle is T0.
  always_comb begin
    sc_clr = !run;
    if (run) begin
      if (t[3] && opcode == OP_REG) sc_clr = 1'b1;
      if (t[4] && (opcode == OP_STA || opcode == OP_BUN)) sc_clr = 1'b1;
      if (t[5] && (opcode == OP_AND || opcode == OP_ADD ||
                   opcode == OP_LDA || opcode == OP_BSA)) sc_clr = 1'b1;
      if (t[6]) sc_clr = 1'b1;
    end
  end

  // Strobe decode. pcCLR belongs to the INIT phase; everything else is a
  // function of the timing state while running.
  always_comb begin
    irLD   = 1'b0;
    arLD   = 1'b0;
    arINR  = 1'b0;
    drLD   = 1'b0;
    drINR  = 1'b0;
    memRD  = 1'b0;
    memWR  = 1'b0;
    pcLD   = 1'b0;
    pcINR  = 1'b0;
    pcCLR  = (phase == PH_INIT);
    ISZ    = 1'b0;
    SPA    = 1'b0;
    SNA    = 1'b0;
    SZA    = 1'b0;
    SZE    = 1'b0;
    busSel = BUS_NONE;
    acOp   = AC_NOP;

    if (run) begin
      // Fetch.
      if (t[0]) begin
        busSel = BUS_PC;
        arLD   = 1'b1;
      end
      if (t[1]) begin
        memRD = 1'b1;
        irLD  = 1'b1;
        pcINR = 1'b1;
      end
      // Decode: address field onto AR.
      if (t[2]) begin
        busSel = BUS_IR;
        arLD   = 1'b1;
      end
      // Indirect fetch, or register-reference execute.
      if (t[3]) begin
        if (opcode != OP_REG) begin
          if (ind) begin
            memRD  = 1'b1;
            arLD   = 1'b1;
            busSel = BUS_MEM;
          end
        end else if (!ind) begin
          acOp = rr_ac_op(rr);
          SPA  = |(rr & RR_SPA);
          SNA  = |(rr & RR_SNA);
          SZA  = |(rr & RR_SZA);
          SZE  = |(rr & RR_SZE);
        end
      end
      // Memory-reference execute.
      if (t[4]) begin
        case (opcode)
          OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
            memRD = 1'b1;
            drLD  = 1'b1;
          end
          OP_STA: begin
            memWR  = 1'b1;
            busSel = BUS_AC;
          end
          OP_BUN: begin
            pcLD   = 1'b1;
            busSel = BUS_AR;
          end
          OP_BSA: begin
            memWR  = 1'b1;
            arINR  = 1'b1;
            busSel = BUS_PC;
          end
          default: ;
        endcase
      end
      if (t[5]) begin
        case (opcode)
          OP_AND: acOp = AC_AND;
          OP_ADD: acOp = AC_ADD;
          OP_LDA: acOp = AC_LOAD;
          OP_BSA: begin
            pcLD   = 1'b1;
            busSel = BUS_AR;
          end
          OP_ISZ: drINR = 1'b1;
          default: ;
        endcase
      end
      // Only ISZ reaches T6: write back the incremented word and let the PC
      // skip when it became zero.
      if (t[6]) begin
        memWR  = 1'b1;
        busSel = BUS_DR;
        ISZ    = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit -- self-checking bench for control_unit.
//
// The reference model expands each instruction word into the list of cycles
// it must produce (timing state, active strobes, bus source, AC operation)
// straight from the instruction-set rules. A stimulus process feeds IR and
// queues those cycles; one compare process checks every meaningful cycle on
// the falling clock edge. Honours CU_HALT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_control_unit;
  import cu_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] IR;
  logic irLD, arLD, arINR, drLD, drINR, memRD, memWR;
  logic pcLD, pcINR, pcCLR, ISZ, SPA, SNA, SZA, SZE;
  logic [2:0] busSel;
  logic [3:0] acOp;
  logic [2:0] sc;
  logic       halted;

  control_unit #(.DATA_W(16), .ADDR_W(12)) dut (
    .CLK(CLK), .RST_N(RST_N), .IR(IR),
    .irLD(irLD), .arLD(arLD), .arINR(arINR), .drLD(drLD), .drINR(drINR),
    .memRD(memRD), .memWR(memWR), .pcLD(pcLD), .pcINR(pcINR), .pcCLR(pcCLR),
    .ISZ(ISZ), .SPA(SPA), .SNA(SNA), .SZA(SZA), .SZE(SZE),
    .busSel(busSel), .acOp(acOp), .sc(sc), .halted(halted)
  );

  always #5 CLK = ~CLK;

  // Strobe bit positions in the bench's cycle vector.
  localparam logic [14:0] S_IRLD  = 15'h0001;
  localparam logic [14:0] S_ARLD  = 15'h0002;
  localparam logic [14:0] S_ARINR = 15'h0004;
  localparam logic [14:0] S_DRLD  = 15'h0008;
  localparam logic [14:0] S_DRINR = 15'h0010;
  localparam logic [14:0] S_MEMRD = 15'h0020;
  localparam logic [14:0] S_MEMWR = 15'h0040;
  localparam logic [14:0] S_PCLD  = 15'h0080;
  localparam logic [14:0] S_PCINR = 15'h0100;
  localparam logic [14:0] S_PCCLR = 15'h0200;
  localparam logic [14:0] S_ISZ   = 15'h0400;
  localparam logic [14:0] S_SPA   = 15'h0800;
  localparam logic [14:0] S_SNA   = 15'h1000;
  localparam logic [14:0] S_SZA   = 15'h2000;
  localparam logic [14:0] S_SZE   = 15'h4000;

  typedef struct packed {
    logic [2:0]  sc;
    logic        halted;
    logic [14:0] str;
    logic [2:0]  bus;
    logic [3:0]  ac;
  } cyc_t;

  // IR bits 11..5 in descending order -> AC operation; bits 4..1 -> skips.
  logic [3:0]  ac_tab   [7] = '{AC_CLA, AC_CLE, AC_CMA, AC_CME, AC_CIR, AC_CIL, AC_INC};
  logic [14:0] skip_tab [4] = '{S_SPA, S_SNA, S_SZA, S_SZE};

  cyc_t exp_q[$];
  cyc_t scr_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic cyc_t mk(input int s, input logic [14:0] str,
                              input logic [2:0] bus, input logic [3:0] ac);
    cyc_t c;
    c.sc     = 3'(s);
    c.halted = 1'b0;
    c.str    = str;
    c.bus    = bus;
    c.ac     = ac;
    return c;
  endfunction

  function automatic cyc_t dut_now();
    cyc_t c;
    c.sc     = sc;
    c.halted = halted;
    c.str    = {SZE, SZA, SNA, SPA, ISZ, pcCLR, pcINR, pcLD,
                memWR, memRD, drINR, drLD, arINR, arLD, irLD};
    c.bus    = busSel;
    c.ac     = acOp;
    return c;
  endfunction

  // Reference model: every cycle an instruction word must produce, T0 onward.
  task automatic model_instr(input logic [15:0] ir);
    logic [2:0]  op;
    logic        ind;
    logic [14:0] sk;
    logic [3:0]  ac;
    op  = ir[14:12];
    ind = ir[15];
    scr_q.delete();
    scr_q.push_back(mk(0, S_ARLD, BUS_PC, AC_NOP));
    scr_q.push_back(mk(1, S_MEMRD | S_IRLD | S_PCINR, BUS_NONE, AC_NOP));
    scr_q.push_back(mk(2, S_ARLD, BUS_IR, AC_NOP));
    if (op == 3'd7) begin
      sk = '0;
      ac = AC_NOP;
      if (!ind) begin
        for (int b = 11; b >= 5; b--) if (ir[b] && ac == AC_NOP) ac = ac_tab[11-b];
        for (int b = 4; b >= 1; b--) if (ir[b]) sk |= skip_tab[4-b];
      end
      scr_q.push_back(mk(3, sk, BUS_NONE, ac));
    end else begin
      if (ind) scr_q.push_back(mk(3, S_MEMRD | S_ARLD, BUS_MEM, AC_NOP));
      else     scr_q.push_back(mk(3, '0, BUS_NONE, AC_NOP));
      case (op)
        3'd0, 3'd1, 3'd2: begin
          scr_q.push_back(mk(4, S_MEMRD | S_DRLD, BUS_NONE, AC_NOP));
          scr_q.push_back(mk(5, '0, BUS_NONE,
                             (op == 3'd0) ? AC_AND : (op == 3'd1) ? AC_ADD : AC_LOAD));
        end
        3'd3: scr_q.push_back(mk(4, S_MEMWR, BUS_AC, AC_NOP));
        3'd4: scr_q.push_back(mk(4, S_PCLD, BUS_AR, AC_NOP));
        3'd5: begin
          scr_q.push_back(mk(4, S_MEMWR | S_ARINR, BUS_PC, AC_NOP));
          scr_q.push_back(mk(5, S_PCLD, BUS_AR, AC_NOP));
        end
        default: begin
          scr_q.push_back(mk(4, S_MEMRD | S_DRLD, BUS_NONE, AC_NOP));
          scr_q.push_back(mk(5, S_DRINR, BUS_NONE, AC_NOP));
          scr_q.push_back(mk(6, S_MEMWR | S_ISZ, BUS_DR, AC_NOP));
        end
      endcase
    end
  endtask

  // INIT cycle follows the first edge after reset release.
  task automatic expect_init();
    @(posedge CLK);
    #1;
    exp_q.push_back(mk(0, S_PCCLR, BUS_NONE, AC_NOP));
  endtask

  // Start an instruction at the edge that begins T0 and return at the edge
  // that begins its last cycle.
  task automatic run_instr(input logic [15:0] ir);
    int n;
    @(posedge CLK);
    #1;
    IR = ir;
    model_instr(ir);
    n = scr_q.size();
    foreach (scr_q[k]) exp_q.push_back(scr_q[k]);
    repeat (n - 1) @(posedge CLK);
  endtask

  // Single compare process.
  always @(negedge CLK) begin : cmp
    cyc_t e;
    cyc_t a;
    if (RST_N && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = dut_now();
      check($sformatf("cycle ir=%04h sc=%0d {sc,halt,strobes,bus,ac}", IR, e.sc),
            32'(a), 32'(e));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    cyc_t c;
    RST_N = 1'b0;
    IR    = '0;
    repeat (3) @(negedge CLK);
    c = dut_now();
    check("reset_sc",      32'(c.sc),     0);
    check("reset_halted",  32'(c.halted), 0);
    check("reset_strobes", 32'(c.str),    0);
    check("reset_bus",     32'(c.bus),    32'(BUS_NONE));
    check("reset_ac",      32'(c.ac),     32'(AC_NOP));

    // Pin the model against hand-worked instructions.
    model_instr(16'h2005);
    check("model_lda_len",   32'(scr_q.size()), 6);
    check("model_lda_t4",    32'(scr_q[4].str), 32'(S_MEMRD | S_DRLD));
    check("model_lda_t5_ac", 32'(scr_q[5].ac),  32'(AC_LOAD));
    model_instr(16'hE010);
    check("model_isz_len", 32'(scr_q.size()), 7);
    check("model_isz_t3",  32'(scr_q[3].str), 32'(S_MEMRD | S_ARLD));
    check("model_isz_t5",  32'(scr_q[5].str), 32'(S_DRINR));
    check("model_isz_t6",  32'(scr_q[6].str), 32'(S_MEMWR | S_ISZ));
    model_instr(16'h701C);
    check("model_skip_len", 32'(scr_q.size()), 4);
    check("model_skip_t3",  32'(scr_q[3].str), 32'(S_SPA | S_SNA | S_SZA));

    // Reset release, then directed instructions.
    @(negedge CLK);
    RST_N = 1'b1;
    expect_init();
    run_instr(16'h2005);
    run_instr(16'hE010);
    run_instr(16'h701C);
    run_instr(16'h7A60);   // CLA wins over CMA/CIL/INC
    run_instr(16'h0123);
    run_instr(16'h9456);
    run_instr(16'hC789);
    run_instr(16'hD002);
    run_instr(16'hF0FF);   // I/O: no strobes
    run_instr(16'h701E);
    run_instr(16'h7020);
`ifndef CU_HALT_EN
    run_instr(16'h7001);   // NOP without the halt option; T0 must follow
`endif

    // Random instructions; a third are forced to register-reference.
    for (int k = 0; k < 250; k++) begin
      logic [15:0] r;
      r = 16'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        r[15]    = 1'b0;
        r[14:12] = 3'd7;
      end
`ifdef CU_HALT_EN
      if (r[14:12] == 3'd7 && !r[15]) r[0] = 1'b0;
`endif
      run_instr(r);
    end

    // Abort a store in T4: the write strobe must fall with reset, not at an edge.
    @(posedge CLK);
    #1;
    IR = 16'h3123;
    model_instr(IR);
    foreach (scr_q[k]) exp_q.push_back(scr_q[k]);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check("abort_memwr",  32'(memWR),  0);
    check("abort_sc",     32'(sc),     0);
    check("abort_bussel", 32'(busSel), 32'(BUS_NONE));
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    expect_init();
    run_instr(16'h2005);
    run_instr(16'h4321);

`ifdef CU_HALT_EN
    // Halt: T0..T3 as usual, then frozen with sc=0 and no strobes.
    @(posedge CLK);
    #1;
    IR = 16'h7001;
    model_instr(IR);
    foreach (scr_q[k]) exp_q.push_back(scr_q[k]);
    for (int k = 0; k < 20; k++) begin
      c = mk(0, '0, BUS_NONE, AC_NOP);
      c.halted = 1'b1;
      exp_q.push_back(c);
    end
    repeat (23) @(posedge CLK);
`endif

    @(negedge CLK);
    #1;
    check("queue_drained", 32'(exp_q.size()), 0);
`ifdef CU_HALT_EN
    RST_N = 1'b0;
    #1;
    check("halt_cleared_by_reset", 32'(halted), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, instruction/data word width.
REQ-002 SHALL have parameter ADDR_W, default 12, address width, equal to PC width.
REQ-003 SHALL have port CLK, input, 1, sole clock; all state updates on posedge.
REQ-004 SHALL have port RST_N, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port IR, input, DATA_W, current instruction register contents.
REQ-006 SHALL have outputs irLD, arLD, arINR, drLD, drINR, memRD, memWR, each 1 bit, datapath strobes.
REQ-007 SHALL have outputs pcLD, pcINR, pcCLR, ISZ, SPA, SNA, SZA, SZE, each 1 bit, PC register controls.
REQ-008 SHALL have outputs busSel (3 bits) and acOp (4 bits), both using package encodings.
REQ-009 SHALL have outputs sc (3 bits, sequence count) and halted (1 bit).

Function
REQ-010 SHALL decode sc into timing states T0..T6; any strobe not listed for a state is 0 in that state.
REQ-011 T0: busSel=PC and arLD=1.
REQ-012 T1: memRD=1, irLD=1 and pcINR=1.
REQ-013 T2: arLD=1 with busSel=IR; opcode=IR[14:12], indirect bit I=IR[15] latched internally.
REQ-014 T3, memory-reference (opcode!=7) with I=1: memRD=1, arLD=1, busSel=MEM; with I=0: no strobes; both advance to T4.
REQ-015 T3, opcode=7, I=0: one strobe per IR bit -- 0x800 CLA, 0x400 CLE, 0x200 CMA, 0x100 CME, 0x080 CIR, 0x040 CIL, 0x020 INC via acOp; 0x010 SPA, 0x008 SNA, 0x004 SZA, 0x002 SZE asserted 1 cycle; pcINR SHALL be 0 in this state; sc clears.
REQ-016 T3, opcode=7, I=1 (I/O, unsupported): no strobes; sc clears.
REQ-017 AND/ADD/LDA: T4 memRD+drLD; T5 acOp=AND/ADD/LOAD; sc clears.
REQ-018 STA: T4 memWR with busSel=AC; sc clears.
REQ-019 BUN: T4 pcLD with busSel=AR; sc clears.
REQ-020 BSA: T4 memWR with busSel=PC, plus arINR; T5 pcLD with busSel=AR; sc clears.
REQ-021 ISZ: T4 memRD+drLD; T5 drINR; T6 memWR with busSel=DR, plus ISZ=1 (the PC tests DR==0); sc clears.
REQ-022 "sc clears" SHALL mean the next cycle is T0; sc never exceeds 6.
REQ-023 Multiple skip bits set together SHALL assert all corresponding strobes in the same cycle.

Reset
REQ-024 While RST_N=0: sc=0, halted=0, all strobes 0, busSel=NONE, acOp=NOP.
REQ-025 First posedge after RST_N deasserts SHALL be an INIT cycle: pcCLR=1 only, sc held at 0; T0 follows.
REQ-026 RST_N asserted mid-instruction SHALL abort immediately, with no partial memWR on the following edge.

Configuration
REQ-027 With CU_HALT_EN defined: IR bit 0x001 at register-reference T3 SHALL set halted=1; while halted, sc stays 0 and all strobes stay 0 until reset.
REQ-028 Without CU_HALT_EN: bit 0x001 SHALL act as NOP and halted SHALL be tied to 0.

Structure
REQ-029 Package cu_pkg SHALL hold opcode constants, register-reference bit masks, busSel encodings (NONE, AR, PC, DR, AC, IR, MEM) and acOp encodings.
REQ-030 Sub-module seq_counter SHALL implement a 3-bit counter with sync clear, async reset and one-hot T decode.

Verification
REQ-031 Reset release -> 1 cycle pcCLR=1, then T0 arLD=1, T1 pcINR=1.
REQ-032 IR=0x2005 (LDA direct) -> T4 drLD, T5 acOp=LOAD, next cycle sc=0; total 6 cycles.
REQ-033 IR=0xE010 (ISZ indirect) -> T3 memRD+arLD, T5 drINR, T6 memWR+ISZ=1, 7 cycles.
REQ-034 IR=0x701C -> T3 SPA=SNA=SZA=1 simultaneously, pcINR=0, next cycle T0.
REQ-035 IR=0x7001 -> with CU_HALT_EN, halted=1 and sc frozen at 0 for 20 cycles; without it, T0 follows.
REQ-036 RST_N pulled low during STA T4 -> memWR drops asynchronously, sc=0, INIT cycle on release.
